ppfifo_stream_writer: RTL and testbench

- Upstream producer stage for the ping-pong FIFO write port.
- Accepts a valid/ready word stream and claims whichever ping-pong buffer is ready.
- Fills that buffer with write_strobe/write_data and releases it when one of these happens: the buffer is full, a last-word marker arrives, or the stream stalls for a programmable timeout.
- Lives entirely in the write clock domain of the ping-pong FIFO.

---
 rtl/ppfifo_stream_writer.sv | 90 +++++++++
 tb/tb_ppfifo_stream_writer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppfifo_stream_writer.sv
// Stream-to-buffer writer for the ping-pong FIFO write port: claims a ready buffer, fills it
// from a valid/ready stream and releases it on full, last-word marker or idle timeout.
module ppfifo_stream_writer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_last,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  input  logic [1:0]               write_ready,
  output logic [1:0]               write_activate,
  input  logic [23:0]              write_fifo_size,
  output logic                     write_strobe,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     busy,
  output logic [31:0]              buffer_count
);

  typedef enum logic [1:0] {StIdle, StActive, StRelease} state_e;

  state_e                   state_q;
  logic [23:0]              count_q;
  logic [TIMEOUT_WIDTH-1:0] idle_q;
  logic [TIMEOUT_WIDTH-1:0] idle_inc;
  logic [23:0]              count_inc;
  logic                     transfer;
  logic                     claim;

  assign in_ready  = (state_q == StActive) && (count_q < write_fifo_size);
  assign transfer  = in_valid && in_ready;
  assign busy      = (state_q != StIdle);
  assign idle_inc  = idle_q + 1'b1;
  assign count_inc = count_q + 24'd1;
  assign claim     = in_valid && (write_ready != 2'b00) && (write_fifo_size != 24'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      count_q        <= '0;
      idle_q         <= '0;
      write_activate <= 2'b00;
      write_strobe   <= 1'b0;
      write_data     <= '0;
      buffer_count   <= '0;
    end else begin
      write_strobe <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (claim) begin
            write_activate <= write_ready[0] ? 2'b01 : 2'b10;
            count_q        <= '0;
            idle_q         <= '0;
            state_q        <= StActive;
          end
        end
        StActive: begin
          if (transfer) begin
            write_strobe <= 1'b1;
            write_data   <= in_data;
            count_q      <= count_inc;
            idle_q       <= '0;
            if ((count_inc == write_fifo_size) || in_last) begin
              state_q <= StRelease;
            end
          end else if ((timeout != '0) && (count_q != '0)) begin
            // An empty claimed buffer never times out; it waits for its first word.
            idle_q <= idle_inc;
            if (idle_inc >= timeout) begin
              state_q <= StRelease;
            end
          end
        end
        StRelease: begin
          // Activate was held through this cycle so the final strobe hit the claimed buffer.
          write_activate <= 2'b00;
          buffer_count   <= buffer_count + 32'd1;
          state_q        <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppfifo_stream_writer.sv
// Directed bench for ppfifo_stream_writer: vector table of burst scenarios plus hand-timed
// sequences for latency, timeout, stalled claim and asynchronous reset.
module tb_ppfifo_stream_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [15:0] timeout = '0;
  logic [1:0]  write_ready;
  logic [1:0]  write_activate;
  logic [23:0] write_fifo_size = 24'd4;
  logic        write_strobe;
  logic [31:0] write_data;
  logic        busy;
  logic [31:0] buffer_count;

  logic        use_model = 1'b1;
  logic [1:0]  manual_ready = 2'b00;
  logic [1:0]  full = 2'b00;

  assign write_ready = use_model ? ~full : manual_ready;

  ppfifo_stream_writer #(
    .DATA_WIDTH   (32),
    .TIMEOUT_WIDTH(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .timeout        (timeout),
    .write_ready    (write_ready),
    .write_activate (write_activate),
    .write_fifo_size(write_fifo_size),
    .write_strobe   (write_strobe),
    .write_data     (write_data),
    .busy           (busy),
    .buffer_count   (buffer_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor-owned records, compared against bench expectations via base indexes.
  logic [31:0] got_q[$];
  logic [1:0]  claim_q[$];
  int          pb_q[$];
  int          strobe_cnt = 0;
  int          viol = 0;
  logic [31:0] exp_q[$];
  int          word_seq = 0;

  // Consumer model: a released buffer becomes full and the other one is drained.
  initial begin : ready_model
    logic [1:0] act_prev;
    act_prev = 2'b00;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        full     = 2'b00;
        act_prev = 2'b00;
      end else begin
        if ((act_prev != 2'b00) && (write_activate == 2'b00)) full = act_prev;
        act_prev = write_activate;
      end
    end
  end

  initial begin : monitor
    logic [1:0] mon_prev;
    int         cur_buf;
    mon_prev = 2'b00;
    cur_buf  = 0;
    forever begin
      @(negedge clk);
      if (write_strobe) begin
        got_q.push_back(write_data);
        strobe_cnt++;
        cur_buf++;
      end
      if ((write_activate != 2'b00) && (mon_prev == 2'b00)) begin
        claim_q.push_back(write_activate);
        cur_buf = 0;
      end
      if ((write_activate == 2'b00) && (mon_prev != 2'b00)) pb_q.push_back(cur_buf);
      if ((in_ready && !busy) || (write_activate == 2'b11) ||
          (write_strobe && (write_activate == 2'b00)) || (busy && (write_activate == 2'b00)))
        viol++;
      mon_prev = write_activate;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_data(input string name, input int gbase, input int ebase);
    int bad;
    int n;
    bad = 0;
    n   = exp_q.size() - ebase;
    check({name, "_len"}, got_q.size() - gbase, n);
    for (int i = 0; i < n; i++) begin
      if ((gbase + i >= got_q.size()) || (got_q[gbase + i] !== exp_q[ebase + i])) bad++;
    end
    check({name, "_order"}, bad, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_stream(input string name, input int n, input int last_idx);
    int i;
    int guard;
    logic fire;
    i     = 0;
    guard = 0;
    while ((i < n) && (guard < 1000)) begin
      in_valid = 1'b1;
      in_data  = 32'hA000_0000 + word_seq;
      in_last  = (i == last_idx);
      fire     = in_ready;
      @(negedge clk);
      if (fire) begin
        exp_q.push_back(in_data);
        word_seq++;
        i++;
      end
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({name, "_sent"}, i, n);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  typedef struct {
    int size;
    int n;
    int last_idx;
    int tmo;
    int exp_strobes;
    int exp_bufs;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int gb, eb, sb, vb, cb, pb, flag;

    vecs[0] = '{size: 4, n: 10, last_idx: 9,  tmo: 0, exp_strobes: 10, exp_bufs: 3};
    vecs[1] = '{size: 1, n: 3,  last_idx: 2,  tmo: 0, exp_strobes: 3,  exp_bufs: 3};
    vecs[2] = '{size: 3, n: 6,  last_idx: -1, tmo: 0, exp_strobes: 6,  exp_bufs: 2};
    vecs[3] = '{size: 8, n: 5,  last_idx: 1,  tmo: 4, exp_strobes: 5,  exp_bufs: 2};
    vecs[4] = '{size: 5, n: 5,  last_idx: 4,  tmo: 0, exp_strobes: 5,  exp_bufs: 1};

    #3;
    check("rst_activate", write_activate, 0);
    check("rst_strobe", write_strobe, 0);
    check("rst_data", write_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_buffer_count", buffer_count, 0);

    for (int k = 0; k < 5; k++) begin
      use_model       = 1'b1;
      write_fifo_size = 24'(vecs[k].size);
      timeout         = 16'(vecs[k].tmo);
      reset_dut();
      gb = got_q.size(); eb = exp_q.size(); sb = strobe_cnt; vb = viol;
      cb = claim_q.size(); pb = pb_q.size();
      send_stream($sformatf("v%0d", k), vecs[k].n, vecs[k].last_idx);
      wait_idle($sformatf("v%0d", k));
      @(negedge clk);
      check($sformatf("v%0d_strobes", k), strobe_cnt - sb, vecs[k].exp_strobes);
      check($sformatf("v%0d_buffers", k), buffer_count, vecs[k].exp_bufs);
      check_data($sformatf("v%0d_data", k), gb, eb);
      check($sformatf("v%0d_protocol", k), viol - vb, 0);
      if (k == 0) begin
        check("v0_claims", claim_q.size() - cb, 3);
        check("v0_claim_seq", {claim_q[cb], claim_q[cb + 1], claim_q[cb + 2]}, 6'b01_10_01);
        check("v0_buf_sizes", {pb_q[pb][7:0], pb_q[pb + 1][7:0], pb_q[pb + 2][7:0]},
              24'h04_04_02);
      end
    end

    // Last on word 3 of a size-8 buffer: exact strobe and release timing.
    use_model = 1'b1; write_fifo_size = 24'd8; timeout = '0;
    reset_dut();
    sb = strobe_cnt;
    in_valid = 1'b1; in_data = 32'h1111_0000; in_last = 1'b0;
    @(negedge clk);
    check("l3_claim", write_activate, 2'b01);
    check("l3_ready", in_ready, 1);
    @(negedge clk);
    check("l3_strobe_lat", {31'd0, write_strobe}, 1);
    check("l3_data0", write_data, 32'h1111_0000);
    in_data = 32'h1111_0001;
    @(negedge clk);
    in_data = 32'h1111_0002; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("l3_release_act_held", write_activate, 2'b01);
    check("l3_release_ready", in_ready, 0);
    check("l3_final_data", write_data, 32'h1111_0002);
    @(negedge clk);
    check("l3_act_fall", write_activate, 0);
    check("l3_busy", busy, 0);
    check("l3_count", buffer_count, 1);
    check("l3_strobes", strobe_cnt - sb, 3);

    // Timeout 5 after two words.
    timeout = 16'd5;
    reset_dut();
    in_valid = 1'b1; in_data = 32'h2222_0000;
    @(negedge clk);
    @(negedge clk);
    in_data = 32'h2222_0001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("to_still_active", in_ready, 1);
    @(negedge clk);
    check("to_release_ready", in_ready, 0);
    check("to_release_act", write_activate, 2'b01);
    @(negedge clk);
    check("to_act_fall", write_activate, 0);
    check("to_count", buffer_count, 1);

    // Claimed but empty buffer never times out.
    timeout = 16'd2;
    reset_dut();
    sb = strobe_cnt;
    in_valid = 1'b1; in_data = 32'h3333_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("empty_busy", busy, 1);
    check("empty_act", write_activate, 2'b01);
    check("empty_count", buffer_count, 0);
    check("empty_strobes", strobe_cnt - sb, 0);

    // Only buffer 1 ready.
    use_model = 1'b0; manual_ready = 2'b10; timeout = '0;
    reset_dut();
    in_valid = 1'b1;
    @(negedge clk);
    check("rdy10_claim", write_activate, 2'b10);
    in_valid = 1'b0;

    // No buffer ready for 20 cycles, then buffer 0 frees up.
    manual_ready = 2'b00;
    reset_dut();
    sb = strobe_cnt; flag = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready || (write_activate != 2'b00) || busy) flag++;
    end
    check("rdy00_held_off", flag, 0);
    check("rdy00_strobes", strobe_cnt - sb, 0);
    manual_ready = 2'b01;
    @(negedge clk);
    check("rdy00_late_claim", write_activate, 2'b01);
    in_valid = 1'b0;

    // Asynchronous reset in the middle of a buffer.
    use_model = 1'b1; write_fifo_size = 24'd4;
    reset_dut();
    in_valid = 1'b1; in_data = 32'h4444_0000;
    @(negedge clk);
    @(negedge clk);
    in_data = 32'h4444_0001;
    @(negedge clk);
    check("mid_strobe_before", {31'd0, write_strobe}, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_act", write_activate, 0);
    check("arst_strobe", {31'd0, write_strobe}, 0);
    check("arst_ready", in_ready, 0);
    check("arst_count", buffer_count, 0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    gb = got_q.size(); eb = exp_q.size(); sb = strobe_cnt;
    send_stream("post_rst", 4, -1);
    wait_idle("post_rst");
    @(negedge clk);
    check("post_rst_strobes", strobe_cnt - sb, 4);
    check("post_rst_buffers", buffer_count, 1);
    check_data("post_rst_data", gb, eb);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
